grad_pulse_enc: RTL and testbench
=================================

Name: grad_pulse_enc

Overview:
- Driver side of the stochastic weight-update accumulator.
- Accepts one signed gradient per valid/ready handshake and converts it into a fixed-length burst of `prop`/`inc` strobes.
- The number of strobes is proportional to |gradient|; the direction comes from its sign.
- Also supplies the per-cycle random byte for the downstream accumulators.
- Sits between the backprop datapath and the accumulator array.

Parameters:
- GRAD_WIDTH, 8, width of the signed gradient input; legal range 2..9.
- BURST_LEN, 16, number of cycles in one burst; legal range 1..255.
- LFSR_SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01.

Ports:
- clk_in  input  1  clock; all flops on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- grad_in  input  GRAD_WIDTH  signed two's-complement gradient.
- grad_valid_in  input  1  grad_in valid.
- grad_ready_out  output  1  block can accept a gradient.
- abort_in  input  1  cancels an in-progress burst.
- rnd_out  output  8  current LFSR state, fanned out to the accumulators' random input.
- prop_out  output  1  strobe: accumulators update this cycle.
- inc_out  output  1  direction; 1 = increment; meaningful only when prop_out=1, otherwise 0.
- busy_out  output  1  burst in progress.
- done_out  output  1  one-cycle pulse after a burst completes normally.
- event_cnt_out  output  $clog2(BURST_LEN+1)  number of prop_out strobes in the last completed burst.

Behaviour:
- Reset (rst_in=0, async):
  - LFSR = LFSR_SEED (or 8'h01 if the seed is 0).
  - State = IDLE.
  - prop_out=0, inc_out=0, busy_out=0, done_out=0, event_cnt_out=0.
  - grad_ready_out=0 while in reset, then 1 in IDLE.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every cycle in every state; never reaches 0.
- States: IDLE, BURST, DONE.
  - grad_ready_out=1 only in IDLE.
  - busy_out=1 only in BURST.
- IDLE -> BURST on a handshake edge (valid & ready). On that edge:
  - Latch sign = grad_in MSB.
  - mag = |grad_in|, saturated to 2^(GRAD_WIDTH-1)-1 (so the most negative input saturates).
  - p = mag << (9-GRAD_WIDTH), giving an 8-bit probability; default range 0..254.
  - Clear the cycle counter and the event counter.
- BURST lasts exactly BURST_LEN cycles; the first burst cycle is the cycle after the handshake edge.
  - Each cycle: prop_out = (rnd_out < p).
  - inc_out = prop_out & ~sign.
  - Event counter increments on every strobe.
  - p=0 produces no strobes.
  - prop_out is combinational from registered state plus LFSR (no extra register stage).
- BURST -> DONE after the final burst cycle.
  - DONE lasts one cycle with done_out=1 and event_cnt_out updated to the burst's event count.
  - DONE -> IDLE unconditionally.
- event_cnt_out holds its value until the next normal burst completion.
- abort_in=1 during BURST:
  - prop_out is forced to 0 in that same cycle.
  - Next state is IDLE; no done_out pulse; event_cnt_out unchanged.
  - abort_in is ignored in IDLE and DONE.
- grad_valid_in while not ready is ignored. The producer must hold grad_in stable until the handshake.
- Asynchronous reset mid-burst clears all outputs immediately; the burst is lost.
- Back-to-back throughput: one gradient per BURST_LEN+2 cycles.

Optional Feature:
- Macro: GRAD_PULSE_DETERMINISTIC_EN.
- Defined: the stochastic compare is replaced by error diffusion.
  - 8-bit phase register, cleared at handshake.
  - Each burst cycle: {carry, phase} <= phase + p, and prop_out = carry of that addition.
  - Exact strobe count = floor(BURST_LEN*p/256).
  - LFSR and rnd_out are unchanged.
- Undefined: stochastic LFSR compare as above; no phase register is synthesized.

Test Plan:
- Reset with seed A5, release -> rnd_out=A5, ready=1, all other outputs 0; LFSR never 0 over 300 cycles, period 255.
- DETERMINISTIC_EN, grad=+64 -> p=128:
  - first prop 1 cycle after handshake;
  - exactly 8 strobes, all with inc_out=1, within 16 busy cycles;
  - done pulse at cycle 17 after handshake;
  - event_cnt_out=8.
- DETERMINISTIC_EN, grad=-128 (saturates, p=254) -> 15 strobes with inc_out=0; grad=0 -> 0 strobes, done still pulses, event_cnt_out=0.
- Stochastic, 200 bursts of grad=+32 (p=64) -> mean strobes/burst 4.0 ± 0.5; every strobe satisfies rnd_out < 64.
- Abort in burst cycle 5 -> prop_out=0 that cycle, IDLE next cycle, no done pulse, event_cnt_out keeps its previous value; valid held high through the burst is not accepted until IDLE.
- Drive rst_in low mid-burst, asynchronously between clock edges -> busy/prop/ready drop immediately; after release, rnd_out=A5 and a new handshake behaves normally.

Source files
------------

// File: rtl/grad_pulse_enc.sv
// Gradient-to-strobe burst encoder driving the stochastic weight-update accumulators.
// Define GRAD_PULSE_DETERMINISTIC_EN for error-diffusion strobes instead of the LFSR compare.
module grad_pulse_enc #(
    parameter int unsigned GRAD_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 16,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [GRAD_WIDTH-1:0]            grad_in,
    input  logic                             grad_valid_in,
    output logic                             grad_ready_out,
    input  logic                             abort_in,
    output logic [7:0]                       rnd_out,
    output logic                             prop_out,
    output logic                             inc_out,
    output logic                             busy_out,
    output logic                             done_out,
    output logic [$clog2(BURST_LEN+1)-1:0]   event_cnt_out
);

    localparam int unsigned     CntW    = $clog2(BURST_LEN + 1);
    localparam int unsigned     PShift  = 9 - GRAD_WIDTH;
    localparam logic [7:0]      SeedEff = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [CntW-1:0] LastCyc = CntW'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [7:0]            lfsr_q, lfsr_d;
    logic                  sign_q, sign_d;
    logic [7:0]            p_q, p_d;
    logic [CntW-1:0]       cyc_q, cyc_d;
    logic [CntW-1:0]       evt_q, evt_d;
    logic [CntW-1:0]       event_cnt_q, event_cnt_d;
    logic [GRAD_WIDTH-1:0] grad_abs;
    logic [GRAD_WIDTH-2:0] mag;
    logic [7:0]            p_new;
    logic                  hit;

    // Taps 8,6,5,4; a nonzero seed keeps the register out of the all-zero lock-up state.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // The most negative input has no positive twin, so its magnitude saturates.
    always_comb begin
        grad_abs = grad_in[GRAD_WIDTH-1] ? (~grad_in + GRAD_WIDTH'(1)) : grad_in;
        mag      = grad_abs[GRAD_WIDTH-1] ? {(GRAD_WIDTH-1){1'b1}} : grad_abs[GRAD_WIDTH-2:0];
        p_new    = 8'(mag) << PShift;
    end

`ifdef GRAD_PULSE_DETERMINISTIC_EN
    logic [7:0] phase_q, phase_d;
    logic [8:0] phase_sum;
    logic       handshake;

    assign handshake = (state_q == StIdle) & grad_valid_in & ready_q;
    assign phase_sum = {1'b0, phase_q} + {1'b0, p_q};
    assign hit       = phase_sum[8];

    always_comb begin
        phase_d = phase_q;
        if (handshake) begin
            phase_d = 8'h00;
        end else if (state_q == StBurst) begin
            phase_d = phase_sum[7:0];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            phase_q <= 8'h00;
        end else begin
            phase_q <= phase_d;
        end
    end
`else
    assign hit = (lfsr_q < p_q);
`endif

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        p_d         = p_q;
        cyc_d       = cyc_q;
        evt_d       = evt_q;
        event_cnt_d = event_cnt_q;
        prop_out    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grad_valid_in && ready_q) begin
                    state_d = StBurst;
                    sign_d  = grad_in[GRAD_WIDTH-1];
                    p_d     = p_new;
                    cyc_d   = '0;
                    evt_d   = '0;
                end
            end
            StBurst: begin
                prop_out = hit & ~abort_in;
                if (abort_in) begin
                    state_d = StIdle;
                end else begin
                    evt_d = evt_q + CntW'(prop_out);
                    cyc_d = cyc_q + CntW'(1);
                    if (cyc_q == LastCyc) begin
                        state_d     = StDone;
                        event_cnt_d = evt_d;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            ready_q     <= 1'b0;
            lfsr_q      <= SeedEff;
            sign_q      <= 1'b0;
            p_q         <= 8'h00;
            cyc_q       <= '0;
            evt_q       <= '0;
            event_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            lfsr_q      <= lfsr_d;
            sign_q      <= sign_d;
            p_q         <= p_d;
            cyc_q       <= cyc_d;
            evt_q       <= evt_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    assign grad_ready_out = ready_q;
    assign rnd_out        = lfsr_q;
    assign inc_out        = prop_out & ~sign_q;
    assign busy_out       = (state_q == StBurst);
    assign done_out       = (state_q == StDone);
    assign event_cnt_out  = event_cnt_q;

endmodule

// File: tb/tb_grad_pulse_enc.sv
// Self-checking bench for grad_pulse_enc: vector table, random-sequence statistics,
// abort and mid-burst reset sequences, all against a bench-side behavioural model.
module tb_grad_pulse_enc;

    localparam int BURST_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] grad;
    logic       valid;
    logic       ready;
    logic       abort;
    logic [7:0] rnd;
    logic       prop;
    logic       inc;
    logic       busy;
    logic       done;
    logic [4:0] evt_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int last_evt = 0;

    logic [7:0] m_lfsr;

    grad_pulse_enc #(
        .GRAD_WIDTH (8),
        .BURST_LEN  (BURST_LEN),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .grad_in        (grad),
        .grad_valid_in  (valid),
        .grad_ready_out (ready),
        .abort_in       (abort),
        .rnd_out        (rnd),
        .prop_out       (prop),
        .inc_out        (inc),
        .busy_out       (busy),
        .done_out       (done),
        .event_cnt_out  (evt_cnt)
    );

    always #5 clk = ~clk;

    // Reference sequence: polynomial x^8+x^6+x^5+x^4+1, seeded with A5.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // One gradient transaction; abort_at = 0 means run to completion.
    task automatic burst(input logic signed [7:0] g, input int p, input int abort_at,
                         input bit hold_valid, output int cnt);
        int phase;
        bit ep;
        bit neg;
        phase = 0;
        cnt   = 0;
        neg   = (g < 0);
        @(negedge clk);
        grad  = g;
        valid = 1'b1;
        abort = 1'b0;
        #1 chk("ready_idle", ready, 1);
        for (int k = 1; k <= BURST_LEN; k++) begin
            @(negedge clk);
            valid = hold_valid;
            abort = (k == abort_at);
            #1;
            chk("rnd_burst", rnd, m_lfsr);
            chk("busy_burst", busy, 1);
            chk("ready_burst", ready, 0);
            chk("done_burst", done, 0);
`ifdef GRAD_PULSE_DETERMINISTIC_EN
            phase = phase + p;
            ep    = (phase >= 256);
            phase = phase % 256;
`else
            ep = (int'(m_lfsr) < p);
`endif
            if (k == abort_at) ep = 1'b0;
            chk("prop", prop, ep);
            chk("inc", inc, ep && !neg);
            if (ep) cnt++;
            if (k == abort_at) break;
        end
        @(negedge clk);
        abort = 1'b0;
        valid = 1'b0;
        #1;
        if (abort_at > 0) begin
            chk("abort_busy", busy, 0);
            chk("abort_ready", ready, 1);
            chk("abort_no_done", done, 0);
            chk("abort_evt_hold", evt_cnt, last_evt);
        end else begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_prop", prop, 0);
            chk("done_ready", ready, 0);
            chk("evt_cnt", evt_cnt, cnt);
            last_evt = cnt;
        end
    endtask

    typedef struct {
        logic signed [7:0] grad;
        int                p;
        int                det_cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int total;
        int period;
        int zeros;

        vecs[0] = '{8'sd64,   128, 8};
        vecs[1] = '{-8'sd128, 254, 15};
        vecs[2] = '{8'sd0,    0,   0};
        vecs[3] = '{8'sd127,  254, 15};
        vecs[4] = '{-8'sd1,   2,   0};
        vecs[5] = '{8'sd1,    2,   0};
        vecs[6] = '{-8'sd64,  128, 8};
        vecs[7] = '{8'sd32,   64,  4};

        rst_n = 1'b1;
        grad  = 8'h00;
        valid = 1'b0;
        abort = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_prop", prop, 0);
        chk("rst_inc", inc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_evt", evt_cnt, 0);
        chk("rst_rnd", rnd, 8'hA5);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_rnd", rnd, 8'hA5);

        period = 0;
        zeros  = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            #1;
            if (rnd == 8'h00) zeros++;
            if (rnd == 8'hA5 && period == 0) period = i;
            if (i == 1) chk("idle_ready", ready, 1);
        end
        chk("lfsr_zero_seen", zeros, 0);
        chk("lfsr_period", period, 255);
        chk("lfsr_model", rnd, m_lfsr);

        foreach (vecs[i]) begin
            burst(vecs[i].grad, vecs[i].p, 0, 1'b0, cnt);
`ifdef GRAD_PULSE_DETERMINISTIC_EN
            chk("det_count", cnt, vecs[i].det_cnt);
            chk("det_floor", cnt, (BURST_LEN * vecs[i].p) / 256);
`endif
        end

`ifndef GRAD_PULSE_DETERMINISTIC_EN
        total = 0;
        for (int b = 0; b < 200; b++) begin
            logic signed [7:0] gr;
            int                pr;
            // Mostly +32; occasional random gradient passes are checked per cycle but not averaged.
            burst(8'sd32, 64, 0, 1'b0, cnt);
            total += cnt;
            if (b % 40 == 0) begin
                gr = 8'($urandom_range(0, 255));
                pr = (gr == -8'sd128) ? 254 : ((gr < 0) ? -int'(gr) : int'(gr)) * 2;
                burst(gr, pr, 0, 1'b0, cnt);
            end
        end
        chk("mean_in_range", (total >= 700 && total <= 900), 1);
`endif

        burst(8'sd64, 128, 0, 1'b0, cnt);
        burst(8'sd127, 254, 5, 1'b1, cnt);
        burst(-8'sd100, 200, 0, 1'b0, cnt);

        @(negedge clk);
        grad  = 8'sd64;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_prop", prop, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_done", done, 0);
        chk("midrst_evt", evt_cnt, 0);
        last_evt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_rnd", rnd, 8'hA5);
        burst(8'sd64, 128, 0, 1'b0, cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
